// File: rtl/sfp_link_pkg.sv
// rtl/sfp_link_pkg.sv - shared SFP link-test types and PRBS31 constants
package sfp_link_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HUNT   = 2'd1,
      LOCKED = 2'd2
   } link_state_t;

   // x^31 + x^28 + 1
   localparam int TAP_A       = 31;
   localparam int TAP_B       = 28;
   localparam int LOCK_LOSS_W = 8;

endpackage

// File: rtl/prbs31_predict.sv
// rtl/prbs31_predict.sv - feed-forward PRBS31 prediction of one word from received bits
module prbs31_predict
   import sfp_link_pkg::*;
#(
   parameter int DATA_W = 40
) (
   input  logic [DATA_W-1:0] cur,
   input  logic [TAP_A-1:0]  prev,
   output logic [DATA_W-1:0] err_vec
);

   // Only the newest TAP_A bits of the previous word can reach any prediction,
   // so h starts there: cur bit i sits at h[TAP_A+i], its taps at h[i] and h[i+3].
   logic [DATA_W+TAP_A-1:0] h;

   assign h = {cur, prev};

   always_comb begin
      err_vec = '0;
      for (int i = 0; i < DATA_W; i++) begin
         err_vec[i] = h[TAP_A + i] ^ h[i] ^ h[i + TAP_A - TAP_B];
      end
   end

endmodule

// File: rtl/sfp_prbs31_rx_checker.sv
// rtl/sfp_prbs31_rx_checker.sv - self-synchronising PRBS31 checker for one SFP RX lane
module sfp_prbs31_rx_checker
   import sfp_link_pkg::*;
#(
   parameter int DATA_W   = 40,
   parameter int LOCK_CNT = 16,
   parameter int LOSS_CNT = 4,
   parameter int CNT_W    = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   rx_ready,
   input  logic                   rx_valid,
   input  logic [DATA_W-1:0]      rx_data,
   input  logic                   clr_cnt,
   output logic                   locked,
   output logic                   err_pulse,
   output logic [CNT_W-1:0]       err_word_cnt,
   output logic [LOCK_LOSS_W-1:0] lock_loss_cnt
);

   localparam int GR_W = $clog2(LOCK_CNT + 1);
   localparam int BR_W = $clog2(LOSS_CNT + 1);
   localparam logic [GR_W-1:0] GR_LAST = GR_W'(LOCK_CNT - 1);
   localparam logic [BR_W-1:0] BR_LAST = BR_W'(LOSS_CNT - 1);

   logic [DATA_W-1:0] cur_q;
   logic [TAP_A-1:0]  prev_q;
   logic [1:0]        hist_cnt;
   logic              eval_q;
   logic [DATA_W-1:0] err_vec;
   logic              word_err;

   link_state_t       state;
   logic [GR_W-1:0]   good_run;
   logic [BR_W-1:0]   bad_run;
   logic              st_err_q;
   logic              st_loss_q;

   prbs31_predict #(.DATA_W(DATA_W)) u_predict (
      .cur     (cur_q),
      .prev    (prev_q),
      .err_vec (err_vec)
   );

   // All-zero satisfies the recurrence, so it must be rejected explicitly.
   assign word_err = (|err_vec) || (cur_q == '0);
   assign locked   = (state == LOCKED);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_q    <= '0;
         prev_q   <= '0;
         hist_cnt <= '0;
         eval_q   <= 1'b0;
      end else if (!rx_ready) begin
         hist_cnt <= '0;
         eval_q   <= 1'b0;
      end else if (rx_valid) begin
         cur_q    <= rx_data;
         prev_q   <= cur_q[DATA_W-1 -: TAP_A];
         eval_q   <= (hist_cnt == 2'd2);
         if (hist_cnt != 2'd2) hist_cnt <= hist_cnt + 2'd1;
      end else begin
         eval_q   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         good_run  <= '0;
         bad_run   <= '0;
         st_err_q  <= 1'b0;
         st_loss_q <= 1'b0;
      end else if (!rx_ready) begin
         state     <= IDLE;
         good_run  <= '0;
         bad_run   <= '0;
         st_err_q  <= 1'b0;
         st_loss_q <= 1'b0;
      end else begin
         st_err_q  <= 1'b0;
         st_loss_q <= 1'b0;
         case (state)
            IDLE: begin
               state    <= HUNT;
               good_run <= '0;
               bad_run  <= '0;
            end
            HUNT: if (eval_q) begin
               if (word_err) begin
                  good_run <= '0;
               end else if (good_run == GR_LAST) begin
                  state    <= LOCKED;
                  good_run <= '0;
                  bad_run  <= '0;
               end else begin
                  good_run <= good_run + 1'b1;
               end
            end
            LOCKED: if (eval_q) begin
               if (word_err) begin
                  st_err_q <= 1'b1;
                  if (bad_run == BR_LAST) begin
                     state     <= HUNT;
                     st_loss_q <= 1'b1;
                     bad_run   <= '0;
                     good_run  <= '0;
                  end else begin
                     bad_run <= bad_run + 1'b1;
                  end
               end else begin
                  bad_run <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Status registered one edge earlier lands here; a clear beats a same-cycle increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_pulse     <= 1'b0;
         err_word_cnt  <= '0;
         lock_loss_cnt <= '0;
      end else begin
         err_pulse <= rx_ready && st_err_q;
         if (clr_cnt) begin
            err_word_cnt  <= '0;
            lock_loss_cnt <= '0;
         end else if (rx_ready) begin
            if (st_err_q && (err_word_cnt != '1))
               err_word_cnt <= err_word_cnt + 1'b1;
            if (st_loss_q && (lock_loss_cnt != '1))
               lock_loss_cnt <= lock_loss_cnt + 1'b1;
         end
      end
   end

endmodule
